// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the RISC-TOY pipeline control unit: opcodes,
// instruction field positions, source-operand decode and FSM states.
package pipe_ctrl_pkg;

  // RISC-TOY opcodes
  localparam logic [4:0] OP_ADDI = 5'd0;
  localparam logic [4:0] OP_ANDI = 5'd1;
  localparam logic [4:0] OP_ORI  = 5'd2;
  localparam logic [4:0] OP_MOVI = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_NEG  = 5'd6;
  localparam logic [4:0] OP_NOT  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_ROR  = 5'd14;
  localparam logic [4:0] OP_BR   = 5'd15;
  localparam logic [4:0] OP_BRL  = 5'd16;
  localparam logic [4:0] OP_J    = 5'd17;
  localparam logic [4:0] OP_JL   = 5'd18;
  localparam logic [4:0] OP_LD   = 5'd19;
  localparam logic [4:0] OP_LDR  = 5'd20;
  localparam logic [4:0] OP_ST   = 5'd21;
  localparam logic [4:0] OP_STR  = 5'd22;

  // Instruction field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 22;
  localparam int RB_MSB  = 21;
  localparam int RB_LSB  = 17;
  localparam int RC_MSB  = 16;
  localparam int RC_LSB  = 12;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Returns {use_rb, use_rc} for the instruction in ID.
  function automatic logic [1:0] src_use(input logic [4:0] opcode);
    logic [1:0] use_v;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_LSR, OP_ASR, OP_SHL, OP_ROR:  use_v = 2'b11;
      OP_NEG, OP_NOT:                  use_v = 2'b01;
      OP_BR, OP_BRL:                   use_v = 2'b10;
      OP_LD, OP_LDR:                   use_v = 2'b10;
      OP_ST, OP_STR:                   use_v = 2'b11;
      default:                         use_v = 2'b00;
    endcase
    return use_v;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] CNT
);

  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_nxt_s;

  // Next count: clear first, then increment unless already at all-ones
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (CLR) begin
      cnt_nxt_s = {W{1'b0}};
    end else if (INC && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_r <= {W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign CNT = cnt_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: load-use stall, taken-branch flush and memory-wait
// freeze for the 5-stage RISC-TOY core, plus debug stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [31:0]      ID_INST,
  input  logic             EX_LOAD,
  input  logic [4:0]       EX_RA,
  input  logic             BR_TAKEN,
  input  logic             MEM_REQ,
  input  logic             MEM_ACK,
  input  logic             CNT_CLR,
  output logic             PC_WE,
  output logic             IFID_WE,
  output logic             IFID_FLUSH,
  output logic             IDEX_WE,
  output logic             IDEX_FLUSH,
  output logic             EXMEM_WE,
  output logic             MEM_ERR,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam int              WCNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_ONE = {{(WCNT_W-1){1'b0}}, 1'b1};

  logic [4:0]        opcode_s;
  logic [4:0]        rb_s;
  logic [4:0]        rc_s;
  logic [1:0]        use_s;
  logic              lu_s;
  logic              fz_s;
  logic              taken_s;
  logic              unused_inst_s;

  state_e            state_r;
  state_e            state_nxt_s;
  logic              pend_flush_r;
  logic              pend_nxt_s;
  logic [WCNT_W-1:0] wait_cnt_r;
  logic [WCNT_W-1:0] wait_cnt_nxt_s;
  logic              mem_err_r;
  logic              mem_err_nxt_s;

  logic              pc_we_s;
  logic              ifid_we_s;
  logic              ifid_flush_s;
  logic              idex_we_s;
  logic              idex_flush_s;
  logic              exmem_we_s;

  assign opcode_s      = ID_INST[OPC_MSB:OPC_LSB];
  assign rb_s          = ID_INST[RB_MSB:RB_LSB];
  assign rc_s          = ID_INST[RC_MSB:RC_LSB];
  assign unused_inst_s = ^{ID_INST[RA_MSB:RA_LSB], ID_INST[RC_LSB-1:0]};
  assign use_s         = src_use(opcode_s);

  assign lu_s    = EX_LOAD & ((use_s[1] & (rb_s == EX_RA)) | (use_s[0] & (rc_s == EX_RA)));
  assign fz_s    = MEM_REQ & ~MEM_ACK;
  assign taken_s = BR_TAKEN | pend_flush_r;

  // Stage control: freeze > taken flush > load-use stall > run
  always_comb begin
    pc_we_s      = 1'b1;
    ifid_we_s    = 1'b1;
    ifid_flush_s = 1'b0;
    idex_we_s    = 1'b1;
    idex_flush_s = 1'b0;
    exmem_we_s   = 1'b1;
    if (fz_s) begin
      pc_we_s    = 1'b0;
      ifid_we_s  = 1'b0;
      idex_we_s  = 1'b0;
      exmem_we_s = 1'b0;
    end else if (taken_s) begin
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
    end else if (lu_s) begin
      pc_we_s      = 1'b0;
      ifid_we_s    = 1'b0;
      idex_flush_s = 1'b1;
    end else begin
      pc_we_s = 1'b1;
    end
  end

  // FSM next state, pending-flush capture, wait counter and timeout flag
  always_comb begin
    state_nxt_s = RUN;
    case (state_r)
      RUN: begin
        if (fz_s) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      WAIT: begin
        if (fz_s) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = RUN;
    endcase

    // A branch resolved under freeze is held until the first unfrozen cycle
    pend_nxt_s = fz_s & (pend_flush_r | BR_TAKEN);

    wait_cnt_nxt_s = {WCNT_W{1'b0}};
    if (state_nxt_s == WAIT) begin
      if (wait_cnt_r == WCNT_MAX) begin
        wait_cnt_nxt_s = wait_cnt_r;
      end else begin
        wait_cnt_nxt_s = wait_cnt_r + WCNT_ONE;
      end
    end else begin
      wait_cnt_nxt_s = {WCNT_W{1'b0}};
    end

    mem_err_nxt_s = mem_err_r | (wait_cnt_nxt_s == WCNT_MAX);
  end

  // Control state registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r      <= RUN;
      pend_flush_r <= 1'b0;
      wait_cnt_r   <= {WCNT_W{1'b0}};
      mem_err_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pend_flush_r <= pend_nxt_s;
      wait_cnt_r   <= wait_cnt_nxt_s;
      mem_err_r    <= mem_err_nxt_s;
    end
  end

  // While in reset, the pipeline must not be enabled or flushed
  assign PC_WE      = pc_we_s      & RSTN;
  assign IFID_WE    = ifid_we_s    & RSTN;
  assign IFID_FLUSH = ifid_flush_s & RSTN;
  assign IDEX_WE    = idex_we_s    & RSTN;
  assign IDEX_FLUSH = idex_flush_s & RSTN;
  assign EXMEM_WE   = exmem_we_s   & RSTN;
  assign MEM_ERR    = mem_err_r;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .RSTN (RSTN),
    .CLR  (CNT_CLR),
    .INC  (~PC_WE),
    .CNT  (STALL_CNT)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK  (CLK),
    .RSTN (RSTN),
    .CLR  (CNT_CLR),
    .INC  (IFID_FLUSH),
    .CNT  (FLUSH_CNT)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit that sequences the IF/ID pipeline register and its neighbours in the 5-stage RISC-TOY core. Each cycle it decides whether every stage advances, holds or is cleared: load-use stall, taken-branch flush and data-memory wait freeze. It drives the IF/ID register's flush input (Branch_Sig), the write enables of the PC and pipeline registers, and keeps saturating stall and flush counters for debug.

## Interface

Parameters:

- MEM_TIMEOUT, 64: maximum number of consecutive memory-wait cycles before MEM_ERR is set.
- CNT_W, 16: width of the stall and flush counters.

Ports:

- CLK  in  1  clock, all state updates on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- ID_INST  in  32  instruction currently in IF/ID. Opcode [31:27], ra [26:22], rb [21:17], rc [16:12].
- EX_LOAD  in  1  instruction in ID/EX is LD or LDR.
- EX_RA  in  5  destination register of the instruction in ID/EX.
- BR_TAKEN  in  1  branch/jump resolved taken in EX this cycle.
- MEM_REQ  in  1  data-memory access in MEM this cycle.
- MEM_ACK  in  1  data memory completes the access this cycle.
- CNT_CLR  in  1  synchronous clear of both counters.
- PC_WE  out  1  PC register update enable.
- IFID_WE  out  1  IF/ID update enable.
- IFID_FLUSH  out  1  clears IF/ID at next edge; connects to Branch_Sig.
- IDEX_WE  out  1  ID/EX update enable.
- IDEX_FLUSH  out  1  loads a bubble (all-zero) into ID/EX at next edge.
- EXMEM_WE  out  1  EX/MEM and MEM/WB update enable.
- MEM_ERR  out  1  sticky memory-timeout flag.
- STALL_CNT  out  CNT_W  cycles with PC_WE=0, saturating.
- FLUSH_CNT  out  CNT_W  taken-branch flushes applied, saturating.

## Operation

- Source use, decoded from the opcode with a package function:
  - rb is used by ADD..ROR (opcodes 4–14, except NEG/NOT, which use rc only), BR/BRL (condition operand), LD/LDR/ST/STR (base).
  - rc is used by all 3-register ALU ops and by ST/STR (store data).
- Load-use hazard (lu) = EX_LOAD & ((use_rb & rb==EX_RA) | (use_rc & rc==EX_RA)).
- Freeze (fz) = MEM_REQ & ~MEM_ACK.
- Priority, highest first:
  1. fz: all WE=0, both flushes=0.
  2. Taken flush, where `taken = BR_TAKEN | pend_flush`: IFID_FLUSH=IDEX_FLUSH=1, all WE=1.
  3. lu: PC_WE=IFID_WE=0, IDEX_FLUSH=1, IDEX_WE=EXMEM_WE=1.
  4. Otherwise RUN: all WE=1, flushes=0.
- pend_flush register:
  - Set when BR_TAKEN & fz, so a branch resolved during a freeze is not lost.
  - Cleared in the first cycle the flush is applied (no fz).
  - BR_TAKEN is sampled only in that one cycle; EX holds under fz, so the flush is re-presented and also latched.
- FSM states:
  - RUN: enter WAIT on fz.
  - WAIT: stay while fz; return to RUN when ~fz.
  - Wait counter: counts cycles in WAIT and clears on leaving WAIT. When it reaches MEM_TIMEOUT, MEM_ERR sets and stays set until reset. The freeze continues regardless of MEM_ERR.
- Counters:
  - STALL_CNT increments every cycle PC_WE=0.
  - FLUSH_CNT increments every cycle IFID_FLUSH=1.
  - Both saturate at all-ones. CNT_CLR has priority over increment.

## Timing

- Control outputs are combinational from the current inputs plus the registered state (pend_flush, FSM state). They are valid in the same cycle and take effect at the next rising edge.
- A load-use stall lasts exactly 1 cycle: the next cycle the load is in MEM and EX_LOAD is deasserted.
- A taken branch costs 2 bubbles: IF/ID and ID/EX are cleared at one edge.
- Reset values (RSTN low, asynchronous):
  - FSM=RUN, pend_flush=0, wait counter=0, MEM_ERR=0, STALL_CNT=0, FLUSH_CNT=0.
  - While RSTN is low, all WE and flush outputs are forced to 0.
- Simultaneous events:
  - BR_TAKEN with lu: flush wins and PC advances to the target.
  - fz with lu: freeze only; lu is re-evaluated after the freeze.
  - Reset during WAIT: returns to RUN and drops pend_flush.

## Structure

- Package pipe_ctrl_pkg holds:
  - opcode localparams (LD=19, LDR=20, ST=21, STR=22, BR=15, BRL=16, etc.);
  - field bit positions;
  - the function src_use(opcode) returning {use_rb, use_rc};
  - the FSM state enum {RUN, WAIT}.
- One sub-module, sat_counter (parameterised width, inc, clr), instantiated twice for the stall and flush counters.

## Test plan

- ID_INST = ADD r3,r1,r2 with EX_LOAD=1, EX_RA=2 → PC_WE=0, IFID_WE=0, IDEX_FLUSH=1 for 1 cycle; STALL_CNT=1. With EX_RA=5 → no stall.
- BR_TAKEN=1 for 1 cycle → IFID_FLUSH=IDEX_FLUSH=1 that cycle; IF/ID INST_out=0 after the edge; FLUSH_CNT=1.
- MEM_REQ=1, MEM_ACK=0 for 3 cycles, then ACK=1 → all WE=0 for 3 cycles; FSM WAIT→RUN; STALL_CNT=3; MEM_ERR=0.
- BR_TAKEN=1 during a freeze, then BR_TAKEN=0 and ACK arrives → the flush is applied in the first unfrozen cycle (pend_flush); FLUSH_CNT=1.
- MEM_REQ=1, ACK=0 for 64 cycles with MEM_TIMEOUT=64 → MEM_ERR=1 and remains 1 after ACK; RSTN pulse → MEM_ERR=0, counters 0.
- Force STALL_CNT to 0xFFFF via a long freeze → it stays 0xFFFF; CNT_CLR=1 → 0 at the next edge.
